// File: rtl/cla_pkg.sv
// Shared types and lookahead helper for the pipelined carry-lookahead adder.
// A stage payload is split into this control struct plus a data word.
package cla_pkg;

  // Group width handled by one lookahead unit.
  localparam int LA_W = 4;

  // Per-stage control. The data word holds resolved low sum bits plus unresolved upper operand A bits.
  typedef struct packed {
    logic valid;
    logic carry;
    logic ovf;
  } stage_ctl_t;

  // Group generate/propagate of one LA_W-bit group, returned as {G, P}.
  function automatic logic [1:0] gp_lookahead(input logic [LA_W-1:0] g,
                                              input logic [LA_W-1:0] p);
    logic gg;
    gg = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
    return {gg, &p};
  endfunction

endpackage

// File: rtl/cla_block.sv
// Combinational BLOCK-bit carry-lookahead slice: group lookahead between
// 4-bit groups, bit carries inside each group from the group carry-in.
module cla_block
  import cla_pkg::*;
#(
  parameter int BLOCK = 16
) (
  input  logic [BLOCK-1:0] a,
  input  logic [BLOCK-1:0] b,
  input  logic             ci,
  output logic [BLOCK-1:0] s,
  output logic             co,
  output logic             cmsb
);

  localparam int NIB  = (BLOCK + LA_W - 1) / LA_W;
  localparam int PADW = NIB * LA_W;

  logic [PADW-1:0] g;
  logic [PADW-1:0] p;
  logic [PADW-1:0] c;

  always_comb begin
    logic       grp_c;
    logic       bit_c;
    logic [1:0] gp;
    g = '0;
    p = '0;
    c = '0;
    g[BLOCK-1:0] = a & b;
    p[BLOCK-1:0] = a ^ b;
    grp_c = ci;
    for (int k = 0; k < NIB; k++) begin
      bit_c = grp_c;
      for (int j = 0; j < LA_W; j++) begin
        c[k*LA_W + j] = bit_c;
        bit_c = g[k*LA_W + j] | (p[k*LA_W + j] & bit_c);
      end
      gp    = gp_lookahead(g[k*LA_W +: LA_W], p[k*LA_W +: LA_W]);
      grp_c = gp[1] | (gp[0] & grp_c);
    end
  end

  assign s    = p[BLOCK-1:0] ^ c[BLOCK-1:0];
  assign co   = g[BLOCK-1] | (p[BLOCK-1] & c[BLOCK-1]);
  assign cmsb = c[BLOCK-1];

endmodule

// File: rtl/cla_pipe_adder.sv
// Pipelined carry-lookahead adder/subtractor: one BLOCK-bit slice resolved per
// stage, valid/ready handshake with a global stall on output back-pressure.
module cla_pipe_adder
  import cla_pkg::*;
#(
  parameter int WIDTH = 64,
  parameter int BLOCK = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] op1,
  input  logic [WIDTH-1:0] op2,
  input  logic             sub,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             crout,
  output logic             ovf
);

  localparam int STAGES = WIDTH / BLOCK;

  logic advance;

  assign advance  = !out_valid || out_ready;
  assign in_ready = advance;

  for (genvar gi = 0; gi < STAGES; gi++) begin : stg
    localparam int LO = gi * BLOCK;
    localparam int RW = WIDTH - LO;

    logic [WIDTH-1:0] word_in;
    logic [WIDTH-1:0] word_next;
    logic [WIDTH-1:0] word_reg;
    logic [RW-1:0]    b_in;
    stage_ctl_t       ctl_in;
    stage_ctl_t       ctl_next;
    stage_ctl_t       ctl_reg;
    logic [BLOCK-1:0] s;
    logic             co;
    logic             cmsb;

    if (gi == 0) begin : src
      assign word_in = op1;
      assign b_in    = op2 ^ {WIDTH{sub}};
      assign ctl_in  = '{valid: in_valid, carry: sub | cin, ovf: 1'b0};
    end else begin : src
      assign word_in = stg[gi-1].word_reg;
      assign b_in    = stg[gi-1].fwd.b_reg;
      assign ctl_in  = stg[gi-1].ctl_reg;
    end

    cla_block #(.BLOCK(BLOCK)) u_cla (
      .a    (word_in[LO +: BLOCK]),
      .b    (b_in[BLOCK-1:0]),
      .ci   (ctl_in.carry),
      .s    (s),
      .co   (co),
      .cmsb (cmsb)
    );

    // Overflow only exists at the MSB slice; earlier stages carry a constant 0 forward.
    always_comb begin
      word_next              = word_in;
      word_next[LO +: BLOCK] = s;
      ctl_next.valid         = ctl_in.valid;
      ctl_next.carry         = co;
      ctl_next.ovf           = (gi == STAGES - 1) ? (cmsb ^ co) : ctl_in.ovf;
    end

    always_ff @(posedge clock) begin
      if (reset) begin
        word_reg <= '0;
        ctl_reg  <= '0;
      end else if (advance) begin
        word_reg <= word_next;
        ctl_reg  <= ctl_next;
      end
    end

    if (gi < STAGES - 1) begin : fwd
      logic [RW-BLOCK-1:0] b_reg;
      always_ff @(posedge clock) begin
        if (reset) begin
          b_reg <= '0;
        end else if (advance) begin
          b_reg <= b_in[RW-1:BLOCK];
        end
      end
    end
  end

  assign out_valid = stg[STAGES-1].ctl_reg.valid;
  assign crout     = stg[STAGES-1].ctl_reg.carry;
  assign ovf       = stg[STAGES-1].ctl_reg.ovf;
  assign sum       = stg[STAGES-1].word_reg;

endmodule

// File: tb/tb_cla_pipe_adder.sv
// Bench for cla_pipe_adder: three parameter sets share one random stimulus,
// each checked every cycle against an arithmetic model with a latency scoreboard.
module tb_cla_pipe_adder;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        out_ready;
  logic [63:0] op1;
  logic [63:0] op2;
  logic        sub;
  logic        cin;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [63:0] s;
    logic        c;
    logic        o;
    int          acc;
    int          stl;
  } exp_t;

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [65:0] act, input logic [65:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: actual=%0h required=%0h", nm, act, req);
    end
  endtask

  // Returns {ovf, carry_out, sum} for a w-bit add/sub computed with wide integer arithmetic.
  function automatic logic [65:0] model(input logic [63:0] a, input logic [63:0] b,
                                        input logic s, input logic c, input int w);
    logic [63:0] mask;
    logic [63:0] am;
    logic [63:0] bm;
    logic [64:0] full;
    logic [63:0] sm;
    logic        co;
    logic        ov;
    mask = (w == 64) ? 64'hffff_ffff_ffff_ffff : ((64'd1 << w) - 64'd1);
    am   = a & mask;
    bm   = (s ? ~b : b) & mask;
    full = {1'b0, am} + {1'b0, bm} + {64'd0, (s | c)};
    sm   = full[63:0] & mask;
    co   = full[w];
    ov   = (am[w-1] == bm[w-1]) && (sm[w-1] != am[w-1]);
    return {ov, co, sm};
  endfunction

  for (genvar gi = 0; gi < 3; gi++) begin : cfg
    localparam int W   = (gi == 2) ? 32 : 64;
    localparam int B   = (gi == 0) ? 16 : ((gi == 1) ? 64 : 8);
    localparam int LAT = W / B;

    logic         in_ready;
    logic         out_valid;
    logic         crout;
    logic         ovf;
    logic [W-1:0] sum;
    exp_t         q[$];
    int           cyc = 0;
    int           stall_cnt = 0;

    cla_pipe_adder #(.WIDTH(W), .BLOCK(B)) dut (
      .clock     (clk),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .op1       (op1[W-1:0]),
      .op2       (op2[W-1:0]),
      .sub       (sub),
      .cin       (cin),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .sum       (sum),
      .crout     (crout),
      .ovf       (ovf)
    );

    // An accepted item is due LAT cycles later, pushed back by each stalled cycle.
    always @(negedge clk) begin
      logic [65:0] m;
      logic        exp_ov;
      if (reset) begin
        q.delete();
      end else begin
        exp_ov = (q.size() > 0) && ((cyc - q[0].acc) == (LAT + stall_cnt - q[0].stl));
        chk($sformatf("c%0d out_valid cyc=%0d", gi, cyc), 66'(out_valid), 66'(exp_ov));
        chk($sformatf("c%0d in_ready cyc=%0d", gi, cyc), 66'(in_ready), 66'(!exp_ov || out_ready));
        if (out_valid && exp_ov) begin
          chk($sformatf("c%0d sum cyc=%0d", gi, cyc), 66'(sum), 66'(q[0].s));
          chk($sformatf("c%0d crout cyc=%0d", gi, cyc), 66'(crout), 66'(q[0].c));
          chk($sformatf("c%0d ovf cyc=%0d", gi, cyc), 66'(ovf), 66'(q[0].o));
        end
        if (exp_ov && out_ready) void'(q.pop_front());
        if (exp_ov && !out_ready) stall_cnt++;
        if (in_valid && (!exp_ov || out_ready)) begin
          m = model(op1, op2, sub, cin, W);
          q.push_back('{s: m[63:0], c: m[64], o: m[65], acc: cyc, stl: stall_cnt});
        end
      end
      cyc++;
    end
  end

  task automatic drive(input logic v, input logic r);
    int sel;
    @(posedge clk);
    #1;
    in_valid  = v;
    out_ready = r;
    op1 = {$urandom, $urandom};
    sel = $urandom_range(0, 3);
    op2 = (sel == 0) ? ~op1 : ((sel == 1) ? (64'd0 - op1) : {$urandom, $urandom});
    sub = $urandom_range(0, 2) == 0;
    cin = $urandom_range(0, 1) == 1;
  endtask

  task automatic drive_vec(input logic [63:0] a, input logic [63:0] b,
                           input logic s, input logic c);
    @(posedge clk);
    #1;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    op1 = a;
    op2 = b;
    sub = s;
    cin = c;
  endtask

  // One transaction into an empty pipe; checks latency and literal results on the default instance.
  task automatic directed(input string nm, input logic [63:0] a, input logic [63:0] b,
                          input logic s, input logic c, input logic [63:0] es,
                          input logic ec, input logic eo);
    int k;
    drive_vec(a, b, s, c);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    k = 1;
    while (k < 20) begin
      @(negedge clk);
      if (cfg[0].out_valid) break;
      @(posedge clk);
      #1;
      k++;
    end
    chk({nm, " latency"}, 66'(k), 66'd4);
    if (k < 20) begin
      chk({nm, " sum"}, 66'(cfg[0].sum), 66'(es));
      chk({nm, " crout"}, 66'(cfg[0].crout), 66'(ec));
      chk({nm, " ovf"}, 66'(cfg[0].ovf), 66'(eo));
    end
    repeat (6) @(posedge clk);
  endtask

  initial begin
    int cnt;
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    op1 = '0; op2 = '0; sub = 1'b0; cin = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    chk("reset out_valid", 66'(cfg[0].out_valid), 66'd0);
    chk("reset sum", 66'(cfg[0].sum), 66'd0);
    chk("reset crout", 66'(cfg[0].crout), 66'd0);
    chk("reset ovf", 66'(cfg[0].ovf), 66'd0);
    chk("reset in_ready", 66'(cfg[0].in_ready), 66'd1);

    chk("model ones+1", model(64'hffff_ffff_ffff_ffff, 64'd1, 1'b0, 1'b0, 64), {2'b01, 64'd0});
    chk("model vec", model(64'h14ab_78ef_d853_5c7d, 64'h8dfd_eded_cbed_8243, 1'b0, 1'b0, 64),
        {2'b00, 64'ha2a9_66dd_a440_dec0});
    chk("model 0-1", model(64'd0, 64'd1, 1'b1, 1'b0, 64), {2'b00, 64'hffff_ffff_ffff_ffff});
    chk("model max+1", model(64'h7fff_ffff_ffff_ffff, 64'd1, 1'b0, 1'b0, 64),
        {2'b10, 64'h8000_0000_0000_0000});
    chk("model cin", model(64'd0, 64'd0, 1'b0, 1'b1, 64), {2'b00, 64'd1});
    chk("model w32 ones+1", model(64'hffff_ffff, 64'd1, 1'b0, 1'b0, 32), {2'b01, 64'd0});

    directed("ones_plus_1", 64'hffff_ffff_ffff_ffff, 64'd1, 1'b0, 1'b0, 64'd0, 1'b1, 1'b0);
    directed("zero_minus_1", 64'd0, 64'd1, 1'b1, 1'b0, 64'hffff_ffff_ffff_ffff, 1'b0, 1'b0);
    directed("max_plus_1", 64'h7fff_ffff_ffff_ffff, 64'd1, 1'b0, 1'b0,
             64'h8000_0000_0000_0000, 1'b0, 1'b1);
    directed("cin_only", 64'd0, 64'd0, 1'b0, 1'b1, 64'd1, 1'b0, 1'b0);
    directed("sub_cin_ignored", 64'd5, 64'd3, 1'b1, 1'b1, 64'd2, 1'b1, 1'b0);

    // Back-to-back stream starting with a known vector.
    drive_vec(64'h14ab_78ef_d853_5c7d, 64'h8dfd_eded_cbed_8243, 1'b0, 1'b0);
    repeat (20) drive(1'b1, 1'b1);
    drive(1'b0, 1'b1);
    repeat (8) @(posedge clk);

    // Back-pressure with a full pipe.
    repeat (6) drive(1'b1, 1'b1);
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 1'b0);
      @(negedge clk);
      chk($sformatf("stall%0d in_ready", i), 66'(cfg[0].in_ready), 66'd0);
      chk($sformatf("stall%0d out_valid", i), 66'(cfg[0].out_valid), 66'd1);
    end
    repeat (3) drive(1'b1, 1'b1);
    drive(1'b0, 1'b1);
    repeat (8) @(posedge clk);

    // Reset with three transactions in flight.
    repeat (3) drive(1'b1, 1'b1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    chk("post-reset out_valid", 66'(cfg[0].out_valid), 66'd0);
    cnt = 0;
    repeat (10) begin
      @(negedge clk);
      if (cfg[0].out_valid) cnt++;
    end
    chk("flushed results seen", 66'(cnt), 66'd0);

    // Random traffic with random back-pressure.
    repeat (400) drive($urandom_range(0, 9) < 7, $urandom_range(0, 9) < 7);
    drive(1'b0, 1'b1);
    repeat (12) @(posedge clk);
    @(negedge clk);
    chk("c0 leftover", 66'(cfg[0].q.size()), 66'd0);
    chk("c1 leftover", 66'(cfg[1].q.size()), 66'd0);
    chk("c2 leftover", 66'(cfg[2].q.size()), 66'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
